// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds PC, fetches one word per instruction, presents OP/Funct/imm to decode.
// Latency: rvalid -> instr_valid one cycle later; 2-cycle minimum period; waits indefinitely on imem rvalid and on advance.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        advance,
    input  logic        branch_taken,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [5:0]  OP,
    output logic [5:0]  Funct,
    output logic [15:0] imm,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    localparam logic [31:0] PC_INIT = RESET_PC & ~32'h0000_0003;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] br_off;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= PC_INIT;
            instr_q   <= 32'h0;
            retired_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
        end
    end

    assign pc_plus4 = pc_q + 32'd4;

    // beq displacement is a signed word offset relative to pc+4
    assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (advance) begin
                    retired_d = retired_q + 32'd1;
                    pc_d      = branch_taken ? (pc_plus4 + br_off) : pc_plus4;
                    state_d   = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == EXEC);
    assign instr       = instr_q;
    assign OP          = instr_q[31:26];
    assign Funct       = instr_q[5:0];
    assign imm         = instr_q[15:0];
    assign pc          = pc_q;
    assign retired     = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then random traffic checked each cycle against a transaction-level model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        advance;
    logic        branch_taken;

    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc, pc_plus4, retired;
    logic [5:0]  OP, Funct;
    logic [15:0] imm;

    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc, w_pc4, w_ret;
    logic [5:0]  w_op, w_funct;
    logic [15:0] w_imm;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .advance(advance), .branch_taken(branch_taken),
        .instr_valid(instr_valid), .instr(instr), .OP(OP), .Funct(Funct), .imm(imm),
        .pc(pc), .pc_plus4(pc_plus4), .retired(retired)
    );

    // Low address bits of the reset PC must be dropped
    fetch_unit #(.RESET_PC(32'hFFFF_FFFF)) u_wrap (
        .clk(clk), .reset(reset),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .advance(advance), .branch_taken(branch_taken),
        .instr_valid(w_valid), .instr(w_instr), .OP(w_op), .Funct(w_funct), .imm(w_imm),
        .pc(w_pc), .pc_plus4(w_pc4), .retired(w_ret)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Model: an instruction is either being waited for or held; one idle cycle follows reset.
    bit          m_init = 1'b0;
    bit          m_gap, m_have;
    logic [31:0] m_pc, m_instr, m_ret;

    always @(posedge clk) begin
        if (reset) begin
            m_init  = 1'b1;
            m_gap   = 1'b1;
            m_have  = 1'b0;
            m_pc    = 32'h0;
            m_instr = 32'h0;
            m_ret   = 32'h0;
        end else if (m_init) begin
            if (m_gap) begin
                m_gap = 1'b0;
            end else if (!m_have) begin
                if (imem_rvalid) begin
                    m_instr = imem_rdata;
                    m_have  = 1'b1;
                end
            end else if (advance) begin
                m_ret = m_ret + 1;
                if (branch_taken)
                    m_pc = m_pc + 4 + {{14{m_instr[15]}}, m_instr[15:0], 2'b00};
                else
                    m_pc = m_pc + 4;
                m_have = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("m_req",      {31'b0, imem_req},    {31'b0, !m_gap && !m_have});
            chk("m_valid",    {31'b0, instr_valid}, {31'b0, m_have});
            chk("m_addr",     imem_addr, m_pc);
            chk("m_pc",       pc,        m_pc);
            chk("m_pc_plus4", pc_plus4,  m_pc + 32'd4);
            chk("m_instr",    instr,     m_instr);
            chk("m_op",       {26'b0, OP},    {26'b0, m_instr[31:26]});
            chk("m_funct",    {26'b0, Funct}, {26'b0, m_instr[5:0]});
            chk("m_imm",      {16'b0, imm},   {16'b0, m_instr[15:0]});
            chk("m_retired",  retired,   m_ret);
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic drive(input bit rst, input bit rv, input logic [31:0] rd, input bit adv, input bit br);
        reset        = rst;
        imem_rvalid  = rv;
        imem_rdata   = rd;
        advance      = adv;
        branch_taken = br;
    endtask

    // Entered at a negedge in the fetch phase; leaves at the negedge after the advance edge
    task automatic run_instr(input logic [31:0] word, input int wait_cyc, input bit br);
        for (int i = 0; i < wait_cyc; i++) begin
            drive(0, 0, 32'h0, 0, 0);
            tick;
        end
        drive(0, 1, word, 0, 0);
        tick;
        drive(0, 0, 32'h0, 1, br);
        tick;
        drive(0, 0, 32'h0, 0, 0);
    endtask

    initial begin
        drive(1, 0, 32'h0, 0, 0);
        tick;
        tick;
        chk("rst_req",     {31'b0, imem_req},    32'd0);
        chk("rst_valid",   {31'b0, instr_valid}, 32'd0);
        chk("rst_pc",      pc,      32'h0);
        chk("rst_retired", retired, 32'h0);
        chk("rst_op",      {26'b0, OP}, 32'h0);
        chk("rst_imm",     {16'b0, imm}, 32'h0);
        chk("rst_wrap_pc", w_pc,    32'hFFFF_FFFC);

        // Advance during fetch must be ignored
        drive(0, 0, 32'h0, 1, 1);
        tick;
        chk("wrap_pc4", w_pc4, 32'h0000_0000);
        for (int i = 0; i < 3; i++) begin
            chk("wait_req",   {31'b0, imem_req},    32'd1);
            chk("wait_addr",  imem_addr,            32'h0);
            chk("wait_valid", {31'b0, instr_valid}, 32'd0);
            tick;
        end
        drive(0, 1, 32'h0232_8020, 0, 0);
        tick;
        chk("ld_valid", {31'b0, instr_valid}, 32'd1);
        chk("ld_op",    {26'b0, OP},    32'h0);
        chk("ld_funct", {26'b0, Funct}, 32'h20);
        chk("ld_imm",   {16'b0, imm},   32'h8020);
        chk("ld_pc",    pc,      32'h0);
        chk("ld_ret",   retired, 32'h0);

        drive(0, 1, 32'hFFFF_FFFF, 0, 0);
        tick;
        chk("spur_instr", instr, 32'h0232_8020);

        drive(0, 0, 32'h0, 1, 0);
        tick;
        chk("adv_req",  {31'b0, imem_req}, 32'd1);
        chk("adv_pc",   pc,      32'h4);
        chk("adv_ret",  retired, 32'h1);
        chk("wrap_pc",  w_pc,    32'h0);
        chk("wrap_ret", w_ret,   32'h1);

        drive(0, 1, 32'h0232_8020, 0, 0);
        tick;
        chk("zw_valid", {31'b0, instr_valid}, 32'd1);
        chk("zw_funct", {26'b0, Funct}, 32'h20);
        chk("zw_pc",    pc, 32'h4);
        drive(0, 0, 32'h0, 1, 0);
        tick;
        drive(0, 0, 32'h0, 0, 0);
        chk("seq_pc", pc, 32'h8);

        run_instr(32'h1000_003D, 1, 1);
        chk("br_fwd_pc", pc, 32'h100);
        chk("br_fwd_ret", retired, 32'd3);
        run_instr(32'h1000_FFFF, 0, 1);
        chk("br_self_pc", pc, 32'h100);
        chk("br_self_ret", retired, 32'd4);
        run_instr(32'h1000_0003, 2, 1);
        chk("br_p3_pc", pc, 32'h110);
        chk("br_p3_ret", retired, 32'd5);
        run_instr(32'h1000_FFFB, 0, 1);
        chk("br_back_pc", pc, 32'h100);
        run_instr(32'h1000_0003, 0, 0);
        chk("nt_pc", pc, 32'h104);
        chk("nt_pc4", pc_plus4, 32'h108);
        chk("nt_ret", retired, 32'd7);

        drive(0, 1, 32'h1234_5678, 0, 0);
        tick;
        chk("pre_rst_valid", {31'b0, instr_valid}, 32'd1);
        drive(1, 0, 32'h0, 1, 1);
        tick;
        chk("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("mid_rst_req",   {31'b0, imem_req},    32'd0);
        chk("mid_rst_pc",    pc,      32'h0);
        chk("mid_rst_instr", instr,   32'h0);
        chk("mid_rst_ret",   retired, 32'h0);
        drive(0, 0, 32'h0, 0, 0);
        tick;
        chk("post_rst_req", {31'b0, imem_req}, 32'd1);

        for (int c = 0; c < 3000; c++) begin
            logic [31:0] rd;
            bit rv;
            rd = $urandom;
            if ($urandom_range(0, 2) == 0) rd[31:26] = 6'h04;
            rv = imem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            drive($urandom_range(0, 199) == 0, rv, rd,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
            tick;
        end
        drive(0, 0, 32'h0, 0, 0);
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
